// File: rtl/cmd_phys_ctrl_gen_if.sv
// Host-side and pad-wrapper-side signal bundle of the SD command-line physical controller.
// The controller uses the slave view; the host/wrapper side uses the master view.
interface cmd_phys_ctrl_gen_if #(
  parameter int RESP_W = 136,
  parameter int TO_W   = 8
);
  // host side
  logic              strobe_in;
  logic              ack_in;
  logic              idle_in;
  logic [1:0]        resp_type;
  logic [TO_W-1:0]   timeout_cycles;
  logic              retry_en;
  logic              ack_out;
  logic              strobe_out;
  logic [RESP_W-1:0] response;
  logic [1:0]        status;
  logic [1:0]        retry_cnt;
  // pad wrapper side
  logic [RESP_W-1:0] pad_response;
  logic              transmission_complete;
  logic              reception_complete;
  logic              crc_ok;
  logic              reset_wrapper;
  logic              pad_state;
  logic              pad_enable;
  logic              enable_pts_wrapper;
  logic              enable_stp_wrapper;
  logic              load_send;
  logic              long_resp;
  logic              command_timeout;

  modport slave (
    input  strobe_in, ack_in, idle_in, resp_type, timeout_cycles, retry_en,
    input  pad_response, transmission_complete, reception_complete, crc_ok,
    output ack_out, strobe_out, response, status, retry_cnt,
    output reset_wrapper, pad_state, pad_enable, enable_pts_wrapper,
    output enable_stp_wrapper, load_send, long_resp, command_timeout
  );

  modport master (
    output strobe_in, ack_in, idle_in, resp_type, timeout_cycles, retry_en,
    output pad_response, transmission_complete, reception_complete, crc_ok,
    input  ack_out, strobe_out, response, status, retry_cnt,
    input  reset_wrapper, pad_state, pad_enable, enable_pts_wrapper,
    input  enable_stp_wrapper, load_send, long_resp, command_timeout
  );
endinterface

// File: rtl/cmd_phys_ctrl_gen.sv
// SD command-line physical controller: sequences command load/send, response wait and
// capture with timeout and automatic retry, then the host strobe/ack handshake.
module cmd_phys_ctrl_gen #(
  parameter int RESP_W     = 136,
  parameter int SHORT_W    = 48,
  parameter int TO_W       = 8,
  parameter int TO_DEFAULT = 63,
  parameter int MAX_RETRY  = 2,
  parameter int STP_DLY    = 1
) (
  input  logic               sd_clock,
  input  logic               reset,
  cmd_phys_ctrl_gen_if.slave bus
);

  localparam int DW = (STP_DLY > 0) ? $clog2(STP_DLY + 1) : 1;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_IDLE      = 4'd1,
    ST_LOAD      = 4'd2,
    ST_SEND      = 4'd3,
    ST_WAIT_RESP = 4'd4,
    ST_CHECK     = 4'd5,
    ST_RETRY     = 4'd6,
    ST_SEND_RESP = 4'd7,
    ST_WAIT_ACK  = 4'd8,
    ST_SEND_ACK  = 4'd9
  } state_t;

  state_t            state_r, next_state_s;
  logic [1:0]        rtype_r, rtype_nx_s;
  logic [TO_W-1:0]   limit_r, limit_nx_s;
  logic              retry_en_r, retry_en_nx_s;
  logic              crc_err_r, crc_err_nx_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_nx_s;
  logic [DW-1:0]     dwell_r, dwell_nx_s;
  logic [RESP_W-1:0] response_r, response_nx_s;
  logic [1:0]        status_r, status_nx_s;
  logic [1:0]        retry_cnt_r, retry_cnt_nx_s;
  logic              to_hit_s;

  logic rw_r, ps_r, pe_r, pts_r, stp_r, ls_r, so_r, ao_r, cto_r;
  logic rw_s, ps_s, pe_s, pts_s, stp_s, ls_s, so_s, ao_s, cto_s;

  // Next-state and datapath register update logic.
  always_comb begin
    next_state_s   = state_r;
    rtype_nx_s     = rtype_r;
    limit_nx_s     = limit_r;
    retry_en_nx_s  = retry_en_r;
    crc_err_nx_s   = crc_err_r;
    response_nx_s  = response_r;
    status_nx_s    = status_r;
    retry_cnt_nx_s = retry_cnt_r;
    to_hit_s       = (state_r == ST_WAIT_RESP) && (to_cnt_r == limit_r);
    if (bus.idle_in && (state_r != ST_IDLE)) begin
      next_state_s = ST_IDLE;
      status_nx_s  = 2'b11;
    end else begin
      case (state_r)
        ST_RESET: next_state_s = ST_IDLE;
        ST_IDLE: begin
          if (bus.strobe_in) begin
            rtype_nx_s     = bus.resp_type;
            limit_nx_s     = (bus.timeout_cycles == {TO_W{1'b0}}) ? TO_W'(TO_DEFAULT)
                                                                  : bus.timeout_cycles;
            retry_en_nx_s  = bus.retry_en;
            retry_cnt_nx_s = 2'd0;
            next_state_s   = ST_LOAD;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_LOAD: next_state_s = ST_SEND;
        ST_SEND: begin
          if (bus.transmission_complete) begin
            if (rtype_r == 2'b00) begin
              status_nx_s   = 2'b00;
              response_nx_s = {RESP_W{1'b0}};
              next_state_s  = ST_SEND_RESP;
            end else begin
              next_state_s = ST_WAIT_RESP;
            end
          end else begin
            next_state_s = ST_SEND;
          end
        end
        ST_WAIT_RESP: begin
          // a reception in the same cycle as the timeout wins
          if (bus.reception_complete) begin
            if (bus.crc_ok) begin
              if (rtype_r[1]) begin
                response_nx_s = bus.pad_response;
              end else begin
                response_nx_s                = {RESP_W{1'b0}};
                response_nx_s[SHORT_W-1:0]   = bus.pad_response[SHORT_W-1:0];
              end
              status_nx_s  = 2'b00;
              next_state_s = ST_SEND_RESP;
            end else begin
              crc_err_nx_s = 1'b1;
              next_state_s = ST_CHECK;
            end
          end else if (to_hit_s) begin
            crc_err_nx_s = 1'b0;
            next_state_s = ST_CHECK;
          end else begin
            next_state_s = ST_WAIT_RESP;
          end
        end
        ST_CHECK: begin
          status_nx_s = crc_err_r ? 2'b10 : 2'b01;
          if (retry_en_r && (retry_cnt_r < 2'(MAX_RETRY))) begin
            retry_cnt_nx_s = retry_cnt_r + 2'd1;
            next_state_s   = ST_RETRY;
          end else begin
            response_nx_s = crc_err_r ? bus.pad_response : {RESP_W{1'b0}};
            next_state_s  = ST_SEND_RESP;
          end
        end
        ST_RETRY:     next_state_s = ST_LOAD;
        ST_SEND_RESP: next_state_s = ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (bus.ack_in) begin
            next_state_s = ST_SEND_ACK;
          end else begin
            next_state_s = ST_WAIT_ACK;
          end
        end
        ST_SEND_ACK:  next_state_s = ST_IDLE;
        default:      next_state_s = ST_RESET;
      endcase
    end
  end

  // Timeout and STP-dwell counters run only while staying in WAIT_RESP.
  always_comb begin
    to_cnt_nx_s = {TO_W{1'b0}};
    dwell_nx_s  = {DW{1'b0}};
    if ((state_r == ST_WAIT_RESP) && (next_state_s == ST_WAIT_RESP)) begin
      to_cnt_nx_s = (to_cnt_r == limit_r) ? to_cnt_r : to_cnt_r + TO_W'(1);
      dwell_nx_s  = (dwell_r == DW'(STP_DLY)) ? dwell_r : dwell_r + DW'(1);
    end else begin
      to_cnt_nx_s = {TO_W{1'b0}};
      dwell_nx_s  = {DW{1'b0}};
    end
  end

  // Output decode from the upcoming state so the output flops line up with the state.
  always_comb begin
    rw_s  = 1'b0;
    ps_s  = 1'b0;
    pe_s  = 1'b0;
    pts_s = 1'b0;
    stp_s = 1'b0;
    ls_s  = 1'b0;
    so_s  = 1'b0;
    ao_s  = 1'b0;
    cto_s = 1'b0;
    case (next_state_s)
      ST_RESET, ST_IDLE, ST_RETRY: rw_s = 1'b1;
      ST_LOAD: begin
        ps_s  = 1'b1;
        pe_s  = 1'b1;
        pts_s = 1'b1;
      end
      ST_SEND: begin
        ps_s  = 1'b1;
        pe_s  = 1'b1;
        pts_s = 1'b1;
        ls_s  = 1'b1;
      end
      ST_WAIT_RESP: begin
        pe_s  = 1'b1;
        stp_s = (dwell_nx_s == DW'(STP_DLY));
        cto_s = (to_cnt_nx_s == limit_nx_s);
      end
      ST_SEND_RESP, ST_WAIT_ACK: so_s = 1'b1;
      ST_SEND_ACK: begin
        so_s = 1'b1;
        ao_s = 1'b1;
      end
      default: rw_s = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_r     <= ST_RESET;
      rtype_r     <= 2'b00;
      limit_r     <= {TO_W{1'b0}};
      retry_en_r  <= 1'b0;
      crc_err_r   <= 1'b0;
      to_cnt_r    <= {TO_W{1'b0}};
      dwell_r     <= {DW{1'b0}};
      response_r  <= {RESP_W{1'b0}};
      status_r    <= 2'b00;
      retry_cnt_r <= 2'b00;
      rw_r        <= 1'b1;
      ps_r        <= 1'b0;
      pe_r        <= 1'b0;
      pts_r       <= 1'b0;
      stp_r       <= 1'b0;
      ls_r        <= 1'b0;
      so_r        <= 1'b0;
      ao_r        <= 1'b0;
      cto_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      rtype_r     <= rtype_nx_s;
      limit_r     <= limit_nx_s;
      retry_en_r  <= retry_en_nx_s;
      crc_err_r   <= crc_err_nx_s;
      to_cnt_r    <= to_cnt_nx_s;
      dwell_r     <= dwell_nx_s;
      response_r  <= response_nx_s;
      status_r    <= status_nx_s;
      retry_cnt_r <= retry_cnt_nx_s;
      rw_r        <= rw_s;
      ps_r        <= ps_s;
      pe_r        <= pe_s;
      pts_r       <= pts_s;
      stp_r       <= stp_s;
      ls_r        <= ls_s;
      so_r        <= so_s;
      ao_r        <= ao_s;
      cto_r       <= cto_s;
    end
  end

  assign bus.ack_out            = ao_r;
  assign bus.strobe_out         = so_r;
  assign bus.response           = response_r;
  assign bus.status             = status_r;
  assign bus.retry_cnt          = retry_cnt_r;
  assign bus.reset_wrapper      = rw_r;
  assign bus.pad_state          = ps_r;
  assign bus.pad_enable         = pe_r;
  assign bus.enable_pts_wrapper = pts_r;
  assign bus.enable_stp_wrapper = stp_r;
  assign bus.load_send          = ls_r;
  assign bus.long_resp          = rtype_r[1];
  assign bus.command_timeout    = cto_r;

endmodule

// File: tb/tb_cmd_phys_ctrl_gen.sv
// Directed bench for cmd_phys_ctrl_gen: short/long/no response, timeout, CRC retry,
// reception-vs-timeout priority, idle abort and reset during the ack handshake.
module tb_cmd_phys_ctrl_gen;
  localparam int RESP_W = 136;
  localparam int TO_W   = 8;

  logic sd_clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ls_pulses = 0;
  logic ls_prev = 1'b0;

  cmd_phys_ctrl_gen_if #(.RESP_W(RESP_W), .TO_W(TO_W)) bus ();

  cmd_phys_ctrl_gen #(
    .RESP_W(RESP_W), .SHORT_W(48), .TO_W(TO_W), .TO_DEFAULT(63), .MAX_RETRY(2), .STP_DLY(1)
  ) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 sd_clock = ~sd_clock;

  // Count distinct load_send pulses.
  always @(negedge sd_clock) begin
    ls_prev <= bus.load_send;
    if (bus.load_send && !ls_prev) ls_pulses <= ls_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [RESP_W-1:0] got,
                           input logic [RESP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sd_clock);
    #1;
  endtask

  // Accept a command from IDLE; returns with the DUT in LOAD.
  task automatic accept(input logic [1:0] rt, input logic [TO_W-1:0] to, input logic re);
    bus.strobe_in      = 1'b1;
    bus.resp_type      = rt;
    bus.timeout_cycles = to;
    bus.retry_en       = re;
    tick();
    bus.strobe_in = 1'b0;
  endtask

  // From SEND_RESP through WAIT_ACK and SEND_ACK back to IDLE.
  task automatic do_ack(input string tag);
    tick();
    check_val({tag, "_wait_ack_strobe"}, bus.strobe_out, 1);
    check_val({tag, "_wait_ack_noack"}, bus.ack_out, 0);
    bus.ack_in = 1'b1;
    tick();
    check_val({tag, "_send_ack"}, bus.ack_out, 1);
    bus.ack_in = 1'b0;
    tick();
    check_val({tag, "_idle_strobe"}, bus.strobe_out, 0);
    check_val({tag, "_idle_rw"}, bus.reset_wrapper, 1);
  endtask

  initial begin
    logic [RESP_W-1:0] p_long;
    logic [RESP_W-1:0] p_mix;
    logic [RESP_W-1:0] p_crc;
    int ls_base;
    p_long = {8'hA5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    p_mix  = {8'h5A, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
    p_crc  = 136'hC0FFEE;

    reset = 1'b1;
    bus.strobe_in = 1'b0; bus.ack_in = 1'b0; bus.idle_in = 1'b0;
    bus.resp_type = 2'b00; bus.timeout_cycles = 8'd0; bus.retry_en = 1'b0;
    bus.pad_response = '0; bus.transmission_complete = 1'b0;
    bus.reception_complete = 1'b0; bus.crc_ok = 1'b0;
    tick(2);
    check_val("rst_rw", bus.reset_wrapper, 1);
    check_val("rst_strobe", bus.strobe_out, 0);
    check_val("rst_pad_en", bus.pad_enable, 0);
    check_val("rst_resp", bus.response, 0);
    check_val("rst_status", bus.status, 0);
    check_val("rst_retry", bus.retry_cnt, 0);
    reset = 1'b0;
    tick();
    check_val("idle_rw", bus.reset_wrapper, 1);

    // short response
    accept(2'b01, 8'd0, 1'b0);
    check_val("s_load_ps", bus.pad_state, 1);
    check_val("s_load_pts", bus.enable_pts_wrapper, 1);
    check_val("s_load_rw", bus.reset_wrapper, 0);
    check_val("s_load_ls", bus.load_send, 0);
    check_val("s_long", bus.long_resp, 0);
    tick();
    check_val("s_send_ls", bus.load_send, 1);
    tick(9);
    bus.transmission_complete = 1'b1;
    tick();
    bus.transmission_complete = 1'b0;
    check_val("s_wr_ps", bus.pad_state, 0);
    check_val("s_wr_pe", bus.pad_enable, 1);
    check_val("s_wr_stp0", bus.enable_stp_wrapper, 0);
    tick();
    check_val("s_wr_stp1", bus.enable_stp_wrapper, 1);
    bus.pad_response = {RESP_W{1'b1}};
    bus.reception_complete = 1'b1; bus.crc_ok = 1'b1;
    tick();
    bus.reception_complete = 1'b0;
    check_val("s_strobe", bus.strobe_out, 1);
    check_val("s_resp", bus.response, {88'h0, 48'hFFFF_FFFF_FFFF});
    check_val("s_status", bus.status, 2'b00);
    do_ack("s");
    check_val("s_hold_resp", bus.response, {88'h0, 48'hFFFF_FFFF_FFFF});

    // timeout without retry
    bus.pad_response = p_mix;
    accept(2'b01, 8'd5, 1'b0);
    tick();
    bus.transmission_complete = 1'b1;
    tick();
    bus.transmission_complete = 1'b0;
    check_val("t_cto_c1", bus.command_timeout, 0);
    tick(4);
    check_val("t_cto_c5", bus.command_timeout, 0);
    tick();
    check_val("t_cto_c6", bus.command_timeout, 1);
    tick();
    check_val("t_check_cto", bus.command_timeout, 0);
    check_val("t_check_strobe", bus.strobe_out, 0);
    tick();
    check_val("t_strobe", bus.strobe_out, 1);
    check_val("t_status", bus.status, 2'b01);
    check_val("t_resp", bus.response, 0);
    check_val("t_retry", bus.retry_cnt, 0);
    do_ack("t");

    // long response
    accept(2'b10, 8'd0, 1'b0);
    check_val("l_long", bus.long_resp, 1);
    tick();
    bus.transmission_complete = 1'b1;
    tick();
    bus.transmission_complete = 1'b0;
    bus.pad_response = p_long;
    bus.reception_complete = 1'b1; bus.crc_ok = 1'b1;
    tick();
    bus.reception_complete = 1'b0;
    check_val("l_resp", bus.response, p_long);
    check_val("l_status", bus.status, 2'b00);
    do_ack("l");

    // no response
    accept(2'b00, 8'd0, 1'b0);
    tick();
    check_val("n_send_stp", bus.enable_stp_wrapper, 0);
    bus.transmission_complete = 1'b1;
    tick();
    bus.transmission_complete = 1'b0;
    check_val("n_strobe", bus.strobe_out, 1);
    check_val("n_stp", bus.enable_stp_wrapper, 0);
    check_val("n_pad_en", bus.pad_enable, 0);
    check_val("n_resp", bus.response, 0);
    check_val("n_status", bus.status, 2'b00);
    do_ack("n");

    // CRC failure, retries exhausted
    bus.pad_response = p_crc;
    ls_base = ls_pulses;
    accept(2'b01, 8'd0, 1'b1);
    for (int a = 0; a < 3; a++) begin
      check_val("c_load_rw", bus.reset_wrapper, 0);
      check_val("c_load_cnt", bus.retry_cnt, RESP_W'(a));
      tick();
      check_val("c_send_ls", bus.load_send, 1);
      bus.transmission_complete = 1'b1;
      tick();
      bus.transmission_complete = 1'b0;
      bus.reception_complete = 1'b1; bus.crc_ok = 1'b0;
      tick();
      bus.reception_complete = 1'b0;
      check_val("c_check_rw", bus.reset_wrapper, 0);
      check_val("c_check_ls", bus.load_send, 0);
      tick();
      if (a < 2) begin
        check_val("c_retry_rw", bus.reset_wrapper, 1);
        check_val("c_retry_cnt", bus.retry_cnt, RESP_W'(a + 1));
        check_val("c_retry_status", bus.status, 2'b10);
        tick();
      end else begin
        check_val("c_final_strobe", bus.strobe_out, 1);
      end
    end
    check_val("c_status", bus.status, 2'b10);
    check_val("c_retry_final", bus.retry_cnt, 2);
    check_val("c_resp", bus.response, p_crc);
    check_val("c_ls_pulses", RESP_W'(ls_pulses - ls_base), 3);
    do_ack("c");

    // reception and timeout in the same cycle
    accept(2'b01, 8'd2, 1'b1);
    tick();
    bus.transmission_complete = 1'b1;
    tick();
    bus.transmission_complete = 1'b0;
    tick(2);
    check_val("b_cto", bus.command_timeout, 1);
    bus.pad_response = p_mix;
    bus.reception_complete = 1'b1; bus.crc_ok = 1'b1;
    tick();
    bus.reception_complete = 1'b0;
    check_val("b_strobe", bus.strobe_out, 1);
    check_val("b_status", bus.status, 2'b00);
    check_val("b_retry", bus.retry_cnt, 0);
    check_val("b_resp", bus.response, 136'h3333_4444_5555);
    do_ack("b");

    // idle_in abort during SEND
    accept(2'b01, 8'd0, 1'b0);
    tick();
    check_val("i_send_ls", bus.load_send, 1);
    bus.idle_in = 1'b1;
    tick();
    bus.idle_in = 1'b0;
    check_val("i_ls", bus.load_send, 0);
    check_val("i_status", bus.status, 2'b11);
    check_val("i_rw", bus.reset_wrapper, 1);
    check_val("i_resp", bus.response, 136'h3333_4444_5555);

    // reset while waiting for ack
    accept(2'b01, 8'd0, 1'b0);
    tick();
    bus.transmission_complete = 1'b1;
    tick();
    bus.transmission_complete = 1'b0;
    bus.pad_response = {RESP_W{1'b1}};
    bus.reception_complete = 1'b1; bus.crc_ok = 1'b1;
    tick();
    bus.reception_complete = 1'b0;
    tick();
    check_val("r_wait_ack", bus.strobe_out, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("r_strobe", bus.strobe_out, 0);
    check_val("r_resp", bus.response, 0);
    check_val("r_status", bus.status, 0);
    check_val("r_rw", bus.reset_wrapper, 1);
    tick();
    check_val("r_idle_rw", bus.reset_wrapper, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
